// File: rtl/zero_swing_pkg.sv
// Shared definitions for the zero-swing detector window sequencer.
package zero_swing_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DETECT = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/alarm_hit_counter.sv
// Per-channel alarm rising-edge detector with a saturating hit counter.
module alarm_hit_counter
  import zero_swing_pkg::*;
#(
  parameter int unsigned ALARM_HITS = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic alarm_i,
  output logic full_next_o
);

  localparam int unsigned HW = $clog2(ALARM_HITS + 1);
  localparam logic [HW-1:0] HITS_MAX = HW'(ALARM_HITS);

  logic [HW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;

  always_comb begin
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (clr_i) begin
      cnt_d  = '0;
      prev_d = 1'b0;
    end else if (en_i) begin
      prev_d = alarm_i;
      if (alarm_i && !prev_q && (cnt_q != HITS_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Look-ahead verdict so the report can include the final window cycle.
  assign full_next_o = (cnt_d == HITS_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/zero_swing_sequencer.sv
// Settle/detect window sequencer driving the zero-swing detector enable.
module zero_swing_sequencer
  import zero_swing_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned WINDOW_CYC = 100000,
  parameter int unsigned ALARM_HITS = 3,
  parameter int unsigned CW         = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_alarm,
  output logic              detect_enable,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] alarm_flags,
  output logic              alarm_any,
  output logic [WCNT_W-1:0] window_cnt
);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW_CYC - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic              stop_seen_q, stop_seen_d;
  logic              de_q, de_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] flags_q, flags_d;
  logic              any_q, any_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [NUM_CH-1:0] full_next;
  logic              hit_clr, hit_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      stop_seen_q <= 1'b0;
      de_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flags_q     <= '0;
      any_q       <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stop_seen_q <= stop_seen_d;
      de_q        <= de_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      flags_q     <= flags_d;
      any_q       <= any_d;
      wcnt_q      <= wcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stop_seen_d = stop_seen_q;
    case (state_q)
      ST_IDLE: begin
        cyc_d       = '0;
        stop_seen_d = 1'b0;
        if (start && !stop) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          stop_seen_d = 1'b1;
          cyc_d       = '0;
        end else if (cyc_q == SETTLE_LAST) begin
          state_d = ST_DETECT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DETECT: begin
        if (stop) begin
          state_d     = ST_IDLE;
          stop_seen_d = 1'b1;
          cyc_d       = '0;
        end else if (cyc_q == WINDOW_LAST) begin
          state_d = ST_REPORT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_REPORT: begin
        cyc_d = '0;
        if (continuous && !stop && !stop_seen_q) state_d = ST_SETTLE;
        else                                     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state itself.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    de_d    = (state_d == ST_DETECT);
    done_d  = (state_d == ST_REPORT);
    flags_d = flags_q;
    wcnt_d  = wcnt_q;
    if (state_d == ST_REPORT) begin
      flags_d = full_next;
      wcnt_d  = wcnt_q + 1'b1;
    end
    any_d = |flags_d;
  end

  assign hit_clr = (state_d == ST_DETECT) && (state_q != ST_DETECT);
  assign hit_en  = (state_q == ST_DETECT);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_hit
    alarm_hit_counter #(
      .ALARM_HITS (ALARM_HITS)
    ) u_hit (
      .clk_i       (clk),
      .rst_i       (rst),
      .clr_i       (hit_clr),
      .en_i        (hit_en),
      .alarm_i     (ch_alarm[n]),
      .full_next_o (full_next[n])
    );
  end

  assign detect_enable = de_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign alarm_flags   = flags_q;
  assign alarm_any     = any_q;
  assign window_cnt    = wcnt_q;

endmodule

// File: doc/zero_swing_sequencer.md
# zero_swing_sequencer

Window sequencer for the four-channel zero-swing detector. It drives the detector's `detect_enable` in timed settle/detect windows, counts alarm events per channel inside each window, and publishes a per-window alarm verdict. It sits between the system control logic (start/stop/continuous) and the detector's enable input and four alarm outputs.

## Interface
- `SETTLE_CYC`, default 1000: cycles `detect_enable` is held low before each window; must be ≥1.
- `WINDOW_CYC`, default 100000: cycles `detect_enable` is held high per window; must be ≥1.
- `ALARM_HITS`, default 3: alarm rising edges in one window needed to flag a channel; must be ≥1.
- `CW`, default 24: settle/window counter width; must hold max(`SETTLE_CYC`, `WINDOW_CYC`).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: pulse; begins a measurement, honoured only in IDLE.
- `stop`, in, 1: pulse; aborts or ends a measurement.
- `continuous`, in, 1: level; sampled in REPORT to decide whether windows repeat.
- `ch_alarm`, in, 4: detector alarm outputs, bit n = channel n.
- `detect_enable`, out, 1: enable to the detector.
- `busy`, out, 1: high in SETTLE, DETECT and REPORT.
- `done`, out, 1: one-cycle pulse per completed window.
- `alarm_flags`, out, 4: per-channel verdict of the last completed window.
- `alarm_any`, out, 1: OR of `alarm_flags`.
- `window_cnt`, out, 16: completed windows since reset; wraps 0xFFFF→0.

## Operation
- FSM states are IDLE, SETTLE, DETECT and REPORT.
- IDLE:
  - `start` & !`stop` → SETTLE.
  - `start` & `stop` in the same cycle → stay IDLE.
- SETTLE:
  - `detect_enable`=0 for exactly `SETTLE_CYC` cycles, then → DETECT.
  - The detector's internal state clears while its enable is low.
- DETECT:
  - `detect_enable`=1 for exactly `WINDOW_CYC` cycles, then → REPORT.
  - Entering DETECT clears all hit counters and the previous-alarm registers (prev = 0).
  - Each DETECT cycle, channel n increments its hit counter when `ch_alarm[n]` & !prev[n]. The counter saturates at `ALARM_HITS`.
  - An alarm already high on the first DETECT cycle counts as one hit.
  - Edges outside DETECT are ignored.
- REPORT (1 cycle):
  - `alarm_flags[n]` ← (hits[n] == `ALARM_HITS`).
  - `done`=1 and `window_cnt`++.
  - Next state is SETTLE if `continuous` & !`stop` & no stop latched during the window; otherwise IDLE.
- `stop` in SETTLE or DETECT → IDLE next cycle.
  - `detect_enable` drops on that edge.
  - No `done` pulse; `alarm_flags` and `window_cnt` are unchanged.
- `stop` in REPORT: the report completes normally, then → IDLE.
- `start` outside IDLE is ignored.
- Hit counter width is clog2(`ALARM_HITS`+1).

## Timing
- All outputs are registered.
- Reset values: state IDLE; `detect_enable`, `busy`, `done`, `alarm_any` = 0; `alarm_flags` = 0; `window_cnt` = 0; hit counters and prev = 0.
- `rst` mid-operation: all of the above take effect on the next edge, no partial report.
- Single measurement, `start` sampled at cycle t:
  - `busy`=1 from t+1.
  - `detect_enable`=1 on cycles t+1+`SETTLE_CYC` through t+`SETTLE_CYC`+`WINDOW_CYC`.
  - `done` and new `alarm_flags` appear at t+1+`SETTLE_CYC`+`WINDOW_CYC`.
  - `busy`=0 one cycle later.
- `alarm_any` updates in the same cycle as `alarm_flags`.
- Continuous mode: `done` pulses are 1+`SETTLE_CYC`+`WINDOW_CYC` cycles apart.
- `stop` sampled at cycle s in SETTLE/DETECT: `detect_enable`=0 and `busy`=0 at s+1.

## Structure
- Shared package `zero_swing_pkg` holds:
  - the state encoding (IDLE/SETTLE/DETECT/REPORT);
  - `NUM_CH`=4;
  - the `window_cnt` width of 16.
- Sub-module `alarm_hit_counter` (edge detect, saturating counter, clear, enable) is instantiated `NUM_CH` times.
- The FSM and the settle/window counter live in the top module.

## Test plan
Parameters for all scenarios: `SETTLE_CYC`=4, `WINDOW_CYC`=16, `ALARM_HITS`=3.

1. Basic window: `start` at cycle 10 → `busy` from 11; `detect_enable` high cycles 15–30; `done` at 31; `busy` low at 32; `window_cnt`=1; `alarm_flags`=0.
2. Verdict: `ch_alarm[2]` pulses 3× and `ch_alarm[0]` 2× inside DETECT → `alarm_flags`=4'b0100, `alarm_any`=1 at the `done` cycle.
3. Edge semantics:
   - `ch_alarm[1]` held high for the whole window → 1 hit, flag 0.
   - `ch_alarm[1]` toggled 5× → count saturates at 3, flag 1.
   - Pulses during SETTLE do not count.
4. Abort: `stop` on the 5th DETECT cycle → `detect_enable`=0 and `busy`=0 next cycle; no `done`; `alarm_flags` and `window_cnt` keep their prior values. A subsequent `start` runs a full window.
5. Continuous:
   - With `continuous`=1, `done` pulses are exactly 21 cycles apart and flags are overwritten each window.
   - `stop` during REPORT → IDLE after that report, `window_cnt` incremented.
6. Reset/priority:
   - `rst` mid-DETECT → all outputs reset values next cycle.
   - `start`+`stop` together in IDLE → stays IDLE.
   - `start` while `busy` → ignored.
